// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync controller.
//   - 640x480@60 default timing constants
//   - phase_e: phase of a horizontal or vertical scan (active, front porch,
//     sync, back porch)
//   - colour constants for the 3-bit {R,G,B} pixel bus
//   - next_phase(): phase transition helper shared by both scan FSMs
package vga_pkg;

  localparam int CNT_W = 10;  // wide enough for 800 columns / 525 lines

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} phase_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

  // Phase the scan is in once its counter takes the value nxt.
  function automatic phase_e next_phase(input phase_e cur,
                                        input logic [CNT_W-1:0] nxt,
                                        input logic [CNT_W-1:0] act_end,
                                        input logic [CNT_W-1:0] sync_beg,
                                        input logic [CNT_W-1:0] sync_end);
    if (nxt == '0)            return H_ACT;
    else if (nxt == act_end)  return H_FRONT;
    else if (nxt == sync_beg) return H_SYNCP;
    else if (nxt == sync_end) return H_BACK;
    else                      return cur;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel tick divider: one-cycle tick every CLK_DIV clocks while enabled.
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   enable_i run request; low parks the divider at phase 0
//   tick_o   pixel tick (constantly high when CLK_DIV=1 and enabled)
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_q, div_d;

  // Phase 0 ticks, so the first enabled cycle is always a tick.
  assign tick_o = enable_i && !rst_i && (div_q == '0);
  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) div_q <= '0;
    else                    div_q <= div_d;
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA sync controller: scan counters, horizontal/vertical phase FSMs and a
// one-tick output stage that lines up sync/blank with the colour the pattern
// datapath returns for the current column/row.
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   enable_i       run request; low holds everything idle
//   rgb_i          {R,G,B} for the current column_o/row_o
//   column_o/row_o current visible pixel, 0 in blanking
//   rgb_o          blanked colour, one tick behind column_o/row_o
//   hsync_o/vsync_o active-low sync, one tick behind
//   video_on_o     rgb_o carries a visible pixel
//   frame_start_o  one-cycle pulse following the tick of pixel (0,0)
module vga_sync_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [2:0] rgb_i,
  output logic [9:0] column_o,
  output logic [8:0] row_o,
  output logic [2:0] rgb_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_A_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_S_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_S_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_A_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_S_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_S_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  phase_e           h_st_q, h_st_d, v_st_q, v_st_d;
  logic             h_wrap, active;
  logic [2:0]       rgb_q;
  logic             hsync_q, vsync_q, video_on_q, frame_start_q;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  // Next scan position; only committed on a tick.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    v_st_d  = v_st_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      v_st_d  = next_phase(v_st_q, v_cnt_d, V_A_END, V_S_BEG, V_S_END);
    end
    h_st_d = next_phase(h_st_q, h_cnt_d, H_A_END, H_S_BEG, H_S_END);
  end

  assign active = (h_st_q == H_ACT) && (v_st_q == H_ACT);

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_st_q        <= H_ACT;
      v_st_q        <= H_ACT;
      rgb_q         <= BLACK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (tick) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      // Output stage samples the pixel being left, so rgb_i (a function of
      // column_o/row_o) stays aligned with its sync/blank.
      rgb_q         <= active ? rgb_i : BLACK;
      hsync_q       <= (h_st_q != H_SYNCP);
      vsync_q       <= (v_st_q != H_SYNCP);
      video_on_q    <= active;
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign column_o      = active ? h_cnt_q : '0;
  assign row_o         = active ? v_cnt_q[8:0] : '0;
  assign rgb_o         = rgb_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl on a shrunken raster (25x15 pixels, CLK_DIV=2).
// Expected outputs come from a closed-form position model indexed by the
// number of enabled clock edges since the last idle cycle.
module tb_vga_sync_ctrl;
  import vga_pkg::*;

  localparam int DIV = 2;
  localparam int HA = 16, HFP = 2, HS = 4, HB = 3, HT = HA + HFP + HS + HB;
  localparam int VA = 8, VFP = 2, VS = 2, VB = 3, VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic [2:0] rgb;
    logic       hs, vs, vid, fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0;
  logic [2:0] rgb_i;
  logic [9:0] column_o;
  logic [8:0] row_o;
  logic [2:0] rgb_o;
  logic       hsync_o, vsync_o, video_on_o, frame_start_o;

  int   total = 0, bad = 0;
  int   n = 0;  // enabled edges since last idle
  obs_t exp_q[$];

  always #5 clk = ~clk;

  // Pattern: red band for columns 6..10, green elsewhere.
  assign rgb_i = (column_o > 10'd5 && column_o < 10'd11) ? RED : GREEN;

  vga_sync_ctrl #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .rgb_i(rgb_i),
    .column_o(column_o), .row_o(row_o), .rgb_o(rgb_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .video_on_o(video_on_o),
    .frame_start_o(frame_start_o)
  );

  function automatic obs_t model(int k);
    obs_t o;
    int t, cur, h, v, p, ph, pv;
    t   = (k + DIV - 1) / DIV;
    cur = t % FRAME;
    h   = cur % HT;
    v   = cur / HT;
    o.col = (h < HA && v < VA) ? 10'(h) : 10'd0;
    o.row = (h < HA && v < VA) ? 9'(v) : 9'd0;
    o.rgb = BLACK; o.hs = 1'b1; o.vs = 1'b1; o.vid = 1'b0; o.fs = 1'b0;
    if (t > 0) begin
      p  = (t - 1) % FRAME;
      ph = p % HT;
      pv = p / HT;
      o.hs  = !(ph >= HA + HFP && ph < HA + HFP + HS);
      o.vs  = !(pv >= VA + VFP && pv < VA + VFP + VS);
      o.vid = (ph < HA && pv < VA);
      if (o.vid) o.rgb = (ph > 5 && ph < 11) ? RED : GREEN;
      o.fs  = ((k - 1) % DIV == 0) && (p == 0);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: push the expectation for the inputs being applied, then pop
  // and compare once the DUT has taken the edge.
  task automatic step();
    obs_t e, a;
    int   nn;
    nn = (rst || !en) ? 0 : n + 1;
    exp_q.push_back(model(nn));
    @(posedge clk);
    n = nn;
    #1;
    e = exp_q.pop_front();
    a = '{column_o, row_o, rgb_o, hsync_o, vsync_o, video_on_o, frame_start_o};
    chk($sformatf("outputs@n=%0d", n), 32'(a), 32'(e));
  endtask

  initial begin
    int vid_c = 0, hs_c = 0, vs_c = 0, fs_c = 0, red_c = 0, fs2_n = 0;
    bit found;

    // Reset overrides enable.
    en = 1'b1;
    repeat (3) step();
    chk("rst_hsync", 32'(hsync_o), 32'd1);
    chk("rst_fs", 32'(frame_start_o), 32'd0);

    // Two frames from reset release; statistics over the first one.
    rst = 1'b0;
    step();
    chk("first_tick_fs", 32'(frame_start_o), 32'd1);
    vid_c += video_on_o; fs_c += frame_start_o; red_c += (rgb_o == RED);
    hs_c += !hsync_o; vs_c += !vsync_o;
    for (int i = 0; i < FRAME * DIV + 20; i++) begin
      step();
      if (n <= FRAME * DIV) begin
        vid_c += video_on_o; fs_c += frame_start_o; red_c += (rgb_o == RED);
        hs_c += !hsync_o; vs_c += !vsync_o;
      end else if (frame_start_o && fs2_n == 0) fs2_n = n;
    end
    chk("video_on_cycles", 32'(vid_c), 32'(HA * VA * DIV));
    chk("hsync_low_cycles", 32'(hs_c), 32'(HS * VT * DIV));
    chk("vsync_low_cycles", 32'(vs_c), 32'(VS * HT * DIV));
    chk("red_cycles", 32'(red_c), 32'(5 * VA * DIV));
    chk("fs_per_frame", 32'(fs_c), 32'd1);
    chk("fs_period", 32'(fs2_n), 32'(FRAME * DIV + 1));

    // Drop enable mid-frame at column 10, row 3.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * DIV && !found; i++) begin
      if (column_o == 10'd10 && row_o == 9'd3) found = 1'b1;
      else step();
    end
    chk("wait_col10_row3", 32'(found), 32'd1);
    en = 1'b0;
    step();
    chk("drop_hsync", 32'(hsync_o), 32'd1);
    chk("drop_video_on", 32'(video_on_o), 32'd0);
    repeat (5) step();
    en = 1'b1;
    step();
    chk("reenable_fs", 32'(frame_start_o), 32'd1);
    repeat (40) step();

    // Reset while inside vertical sync.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * DIV && !found; i++) begin
      if (vsync_o == 1'b0) found = 1'b1;
      else step();
    end
    chk("wait_vsync", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_vsync_release", 32'(vsync_o), 32'd1);
    chk("rst_rgb", 32'(rgb_o), 32'd0);
    rst = 1'b0;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, system clocks per pixel (legal values 1..4).
REQ-002 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, horizontal front porch, sync and back porch in pixels.
REQ-004 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33, vertical front porch, sync and back porch in lines.
REQ-006 clk_i  input  1  system clock; the block uses one clock only.
REQ-007 rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-008 enable_i  input  1  run request; low holds the controller idle.
REQ-009 rgb_i  input  3  pixel colour from the pattern datapath, {R,G,B}.
REQ-010 column_o  output  10  current pixel column, 0..H_ACTIVE-1.
REQ-011 row_o  output  9  current line, 0..V_ACTIVE-1.
REQ-012 rgb_o  output  3  blanked, pipeline-aligned colour to the DAC pins.
REQ-013 hsync_o, vsync_o  output  1 each  sync pulses, active-low.
REQ-014 video_on_o  output  1  high when rgb_o is a visible pixel.
REQ-015 frame_start_o  output  1  one-clk pulse at the start of each frame.

Function
REQ-016 A pixel tick SHALL assert for one clk_i cycle every CLK_DIV cycles; all counters and pipeline registers SHALL advance only on a tick.
REQ-017 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), and SHALL wrap to 0.
REQ-018 v_cnt SHALL increment on each h_cnt wrap, count 0..V_TOTAL-1, where V_TOTAL = 525, and SHALL wrap to 0 on the tick where both counters are at their maximum.
REQ-019 The horizontal phase FSM SHALL have states H_ACT, H_FRONT, H_SYNCP and H_BACK, in that order.
REQ-020 The FSM SHALL change state on the tick where h_cnt reaches 640, 656, 752 or 0 respectively; the vertical FSM SHALL mirror this at lines 480, 490, 492 and 0.
REQ-021 column_o and row_o SHALL equal h_cnt and v_cnt while both are inside the active area, and SHALL be 0 otherwise.
REQ-022 hsync_o, vsync_o, video_on_o and rgb_o SHALL be registered one pixel tick after the column_o/row_o they correspond to, so the combinational rgb_i stays aligned (latency 1 tick).
REQ-023 rgb_o SHALL equal the registered rgb_i when video_on_o is high, and SHALL be 3'b000 otherwise.
REQ-024 hsync_o SHALL be low during H_SYNCP (96 pixels); vsync_o SHALL be low during the V_SYNC lines (2 lines).
REQ-025 frame_start_o SHALL pulse for exactly one clk_i cycle on the tick where h_cnt=0 and v_cnt=0.
REQ-026 With enable_i low: counters SHALL be held at 0, hsync_o and vsync_o SHALL be 1, video_on_o and rgb_o SHALL be 0, and frame_start_o SHALL be 0.
REQ-027 When enable_i is deasserted mid-frame, the block SHALL return to the idle state of REQ-026 on the next clk_i cycle.
REQ-028 When enable_i is reasserted, the first tick SHALL start at h=0, v=0 and SHALL emit frame_start_o.
REQ-029 At CLK_DIV=1 the tick SHALL be constantly high.

Reset
REQ-030 While rst_i=1 on a clk_i edge: tick counter, h_cnt and v_cnt SHALL be 0 and both FSMs SHALL be in H_ACT.
REQ-031 While rst_i=1: column_o=0, row_o=0, rgb_o=0, video_on_o=0, frame_start_o=0, hsync_o=1 and vsync_o=1.
REQ-032 rst_i SHALL override enable_i; reset mid-frame SHALL abort the frame with no further pulses.

Structure
REQ-033 Package vga_pkg SHALL hold the 640x480@60 timing constants, the FSM state typedef and the colour constants RED=3'b100, GREEN=3'b010, BLUE=3'b001.
REQ-034 The tick divider SHALL be the sub-module pix_tick_gen (clk_i, rst_i, enable_i -> tick_o).
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Reset then enable_i=1 with CLK_DIV=2 -> frame_start_o pulses on the first tick, then every 800*525*2 = 840000 clk_i cycles.
REQ-037 Count one line -> hsync_o is low for exactly 96 ticks, starting 656 ticks after column 0 (plus the 1-tick latency).
REQ-038 Count one frame -> vsync_o is low for 2 lines starting at line 490; video_on_o is high for 640x480 = 307200 ticks.
REQ-039 rgb_i = RED when 213<column<426, else GREEN -> rgb_o is RED for columns 214..425 of each visible line, one tick late, and 000 in blanking.
REQ-040 enable_i dropped at h=300, v=200 -> next cycle all outputs are idle; re-enable -> restart at 0,0 with frame_start_o.
REQ-041 rst_i asserted at line 491 (inside vsync) -> vsync_o is 1 on the next cycle and all outputs take the REQ-031 values.
